atom_npu_mac_vec: RTL and testbench

Parametrised successor to the single-shot NPU core. Computes a signed dot product over VEC_LEN input/weight pairs, streamed one pair per beat with a valid/ready handshake. Accumulates at full precision, then saturates to OUT_W and presents the result with a one-cycle done pulse. Sits between the top-level pin wrapper and the NPU sequencer, and replaces the fixed 4-bit core.

---
 rtl/atom_npu_mac_vec.sv | 120 ++++++++++++
 tb/tb_atom_npu_mac_vec.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/atom_npu_mac_vec.sv
// ============================================================================
// atom_npu_mac_vec : streamed signed dot product, saturated to OUT_W with a done pulse
// Optional macro ATOM_NPU_RELU_EN clamps negative results to zero. Rev 1.0
// ============================================================================
`default_nettype none

module atom_npu_mac_vec #(
  parameter int DATA_W  = 4,
  parameter int VEC_LEN = 4,
  parameter int OUT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] input_data,
  input  logic [DATA_W-1:0] weight,
  output logic              in_ready,
  output logic [OUT_W-1:0]  output_data,
  output logic              done,
  output logic              busy
);

  localparam int ACC_W = 2*DATA_W + $clog2(VEC_LEN) + 1;
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OUT_W-1:0]         output_data_q, output_data_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sum;
  logic [OUT_W-1:0]           result;

  assign prod    = $signed(input_data) * $signed(weight);
  assign acc_sum = acc_q + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});

  // Result is built from acc_sum so it already includes the final beat.
  always_comb begin
    result = acc_sum[OUT_W-1:0];
    if (acc_sum > SAT_MAX) begin
      result = SAT_MAX[OUT_W-1:0];
    end else if (acc_sum < SAT_MIN) begin
      result = SAT_MIN[OUT_W-1:0];
    end
`ifdef ATOM_NPU_RELU_EN
    if (result[OUT_W-1]) begin
      result = '0;
    end
`else
`endif
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    output_data_d = output_data_q;
    in_ready      = 1'b0;
    done          = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          // Register the result on the last beat so it is visible during OUTPUT.
          if (cnt_q == LAST_BEAT) begin
            output_data_d = result;
            state_d       = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      output_data_q <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      output_data_q <= output_data_d;
    end
  end

  assign output_data = output_data_q;

endmodule

`default_nettype wire

// File: tb/tb_atom_npu_mac_vec.sv
// ============================================================================
// tb_atom_npu_mac_vec : directed and random dot products against an arithmetic model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_atom_npu_mac_vec;

  localparam int DATA_W  = 4;
  localparam int VEC_LEN = 4;
  localparam int OUT_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] input_data = '0;
  logic [DATA_W-1:0] weight = '0;
  logic              in_ready;
  logic [OUT_W-1:0]  output_data;
  logic              done;
  logic              busy;

  int errors = 0;
  int checks = 0;

  atom_npu_mac_vec #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .input_data (input_data),
    .weight     (weight),
    .in_ready   (in_ready),
    .output_data(output_data),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain integer dot product, clamp, optional ReLU.
  function automatic logic [OUT_W-1:0] model(input int d[4], input int w[4]);
    int s = 0;
    for (int i = 0; i < 4; i++) s += d[i] * w[i];
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef ATOM_NPU_RELU_EN
    if (s < 0) s = 0;
`endif
    return OUT_W'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dot(input int d[4], input int w[4], input int gap_before, input int gap_len,
                         input bit start_in_gap, input bit junk_with_start, input string tag);
    logic [OUT_W-1:0] exp;
    exp = model(d, w);
    start = 1'b1;
    if (junk_with_start) begin
      in_valid   = 1'b1;
      input_data = 4'd7;
      weight     = 4'd7;
    end
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == gap_before) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          start    = start_in_gap && (g == 0);
          step();
          chk({tag, "_gap_done"}, 32'(done), 32'd0);
        end
        start = 1'b0;
      end
      in_valid   = 1'b1;
      input_data = DATA_W'(d[i]);
      weight     = DATA_W'(w[i]);
      step();
      if (i < 3) chk({tag, "_early_done"}, 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_out"}, 32'(output_data), 32'(exp));
    chk({tag, "_out_ready"}, 32'(in_ready), 32'd0);
    step();
    chk({tag, "_done_end"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'(output_data), 32'(exp));
  endtask

  initial begin
    int da[4];
    int wa[4];
    int gpos;
    int glen;

    #12;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_out", 32'(output_data), 32'd0);
    rst_n = 1'b1;
    step();

    da = '{1, 2, 3, 4};     wa = '{1, 1, 1, 1};
    run_dot(da, wa, -1, 0, 1'b0, 1'b0, "basic");
    da = '{7, 7, 7, 7};     wa = '{7, 7, 7, 7};
    run_dot(da, wa, -1, 0, 1'b0, 1'b0, "satpos");
    da = '{-8, -8, -8, -8}; wa = '{7, 7, 7, 7};
    run_dot(da, wa, -1, 0, 1'b0, 1'b0, "satneg");
    da = '{1, 2, 3, 4};     wa = '{1, 1, 1, 1};
    run_dot(da, wa, 2, 3, 1'b0, 1'b0, "bubble");

    // in_valid without start must not wake the core
    for (int k = 0; k < 3; k++) begin
      in_valid   = 1'b1;
      input_data = 4'd5;
      weight     = 4'd5;
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_out", 32'(output_data), 32'd10);
    end
    in_valid = 1'b0;
    step();

    da = '{1, -2, 3, -4};   wa = '{5, 6, 7, -8};
    run_dot(da, wa, 1, 2, 1'b1, 1'b1, "restart");

    // asynchronous reset after two accepted beats
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid   = 1'b1;
      input_data = 4'd3;
      weight     = 4'd3;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out", 32'(output_data), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("arst_done", 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_out", 32'(output_data), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    da = '{2, 2, 2, 2};     wa = '{3, 3, 3, 3};
    run_dot(da, wa, -1, 0, 1'b0, 1'b0, "after_rst");

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) begin
        da[i] = int'($urandom_range(15)) - 8;
        wa[i] = int'($urandom_range(15)) - 8;
      end
      gpos = int'($urandom_range(4));
      glen = int'($urandom_range(3));
      run_dot(da, wa, gpos, glen, $urandom_range(1) == 1, $urandom_range(1) == 1,
              $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
